// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
//  Package : npu_pkg
//  Shared definitions for the NPU PE datapath: default widths, signed
//  datapath typedefs and width-generic saturating arithmetic helpers.
//  Helpers work on 64-bit signed carriers so that any datapath width up
//  to 62 bits can use them; callers sign-extend in and truncate out.
//  Revision: 1.0  initial release
// ============================================================================
package npu_pkg;

  localparam int DEF_PROD_W  = 16;
  localparam int DEF_ACC_W   = 32;
  localparam int DEF_OUT_W   = 8;
  localparam int DEF_SHIFT_W = 5;

  typedef logic signed [DEF_PROD_W-1:0] prod_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;
  typedef logic signed [DEF_OUT_W-1:0]  out_t;

  // Result of a saturating add: value already clamped to the target width,
  // plus a flag telling whether clamping happened.
  typedef struct packed {
    logic               clamped;
    logic signed [63:0] value;
  } sat_res_t;

  // a + b clamped to the signed range of a w-bit number.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int                 w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] s;
    sat_res_t           r;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    s  = a + b;
    r.clamped = 1'b0;
    r.value   = s;
    if (s > hi) begin
      r.clamped = 1'b1;
      r.value   = hi;
    end else if (s < lo) begin
      r.clamped = 1'b1;
      r.value   = lo;
    end
    return r;
  endfunction

  // x clamped to the signed range of a w-bit number.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] x,
                                                    input int                 w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage : npu_pkg
`default_nettype wire

// File: rtl/mac_accum_requant_if.sv
`default_nettype none
// ============================================================================
//  Interface : mac_accum_requant_if
//  Product-beat input stream, per-vector configuration and requantised
//  result stream of the MAC accumulate/requantise stage.
//    in_valid/in_ready/in_prod/in_last : product beat handshake
//    cfg_bias/cfg_shift/cfg_relu        : taken on the first beat of a vector
//    out_valid/out_ready                : result handshake
//    out_data/out_acc/out_ovf           : int8 result, raw accumulator, overflow
//  Modports: master = producer/consumer side, slave = the block itself.
//  Revision: 1.0  initial release
// ============================================================================
interface mac_accum_requant_if #(
  parameter int PROD_W  = 16,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [PROD_W-1:0]  in_prod;
  logic                      in_last;
  logic signed [ACC_W-1:0]   cfg_bias;
  logic        [SHIFT_W-1:0] cfg_shift;
  logic                      cfg_relu;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   out_data;
  logic signed [ACC_W-1:0]   out_acc;
  logic                      out_ovf;

  modport master (
    output in_valid, in_prod, in_last, cfg_bias, cfg_shift, cfg_relu, out_ready,
    input  in_ready, out_valid, out_data, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, cfg_bias, cfg_shift, cfg_relu, out_ready,
    output in_ready, out_valid, out_data, out_acc, out_ovf
  );
endinterface : mac_accum_requant_if
`default_nettype wire

// File: rtl/mac_accum_requant_rsr.sv
`default_nettype none
// ============================================================================
//  Module : requant_rsr
//  Combinational requantiser: round-half-up arithmetic right shift,
//  optional ReLU, then saturation to a signed OUT_W result.
//    acc_in : signed ACC_W accumulator value
//    shift  : right-shift amount (0 = no rounding, pass through)
//    relu   : clamp negative values to zero after rounding
//    data   : signed OUT_W saturated result
//  Revision: 1.0  initial release
// ============================================================================
module requant_rsr
  import npu_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic signed [ACC_W-1:0]   acc_in,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                      relu,
  output logic signed [OUT_W-1:0]   data
);

  // One guard bit so adding the rounding half can never wrap.
  logic signed [ACC_W:0] w_ext;
  logic signed [ACC_W:0] w_half;
  logic signed [ACC_W:0] w_rnd;
  logic signed [ACC_W:0] w_relu;

  always_comb begin
    w_ext  = (ACC_W+1)'(acc_in);
    w_half = '0;
    w_rnd  = w_ext;
    if (shift != '0) begin
      w_half = (ACC_W+1)'(1) << (shift - SHIFT_W'(1));
      w_rnd  = (w_ext + w_half) >>> shift;
    end
    w_relu = (relu && (w_rnd < 0)) ? '0 : w_rnd;
    data   = OUT_W'(sat_narrow(64'(w_relu), OUT_W));
  end

endmodule : requant_rsr
`default_nettype wire

// File: rtl/mac_accum_requant.sv
`default_nettype none
// ============================================================================
//  Module : mac_accum_requant
//  Accumulates a stream of signed products into a saturating accumulator
//  seeded with a per-vector bias; on the last beat of a vector the sum is
//  requantised (round-shift, optional ReLU, int saturate) and presented on
//  a valid/ready result port together with the raw sum and overflow flag.
//    clk : rising-edge clock
//    rst : synchronous active-high reset
//    bus : mac_accum_requant_if.slave (beat input, cfg, result output)
//  Revision: 1.0  initial release
// ============================================================================
module mac_accum_requant
  import npu_pkg::*;
#(
  parameter int PROD_W  = DEF_PROD_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  mac_accum_requant_if.slave   bus
);

  // Accumulation state
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_first;
  logic                      r_ovf;
  logic        [SHIFT_W-1:0] r_shift;
  logic                      r_relu;

  // Output register
  logic                      r_out_valid;
  logic signed [OUT_W-1:0]   r_out_data;
  logic signed [ACC_W-1:0]   r_out_acc;
  logic                      r_out_ovf;

  logic                      w_ready;
  logic                      w_accept;
  logic signed [ACC_W-1:0]   w_base;
  sat_res_t                  w_res;
  logic signed [ACC_W-1:0]   w_sum;
  logic                      w_clamp;
  logic        [SHIFT_W-1:0] w_eff_shift;
  logic                      w_eff_relu;
  logic signed [OUT_W-1:0]   w_req_data;

  // Ready depends only on registered state and out_ready, never on in_valid.
  assign w_ready  = !r_out_valid || bus.out_ready;
  assign w_accept = bus.in_valid && w_ready;

  // On the first beat the live cfg values apply directly, so a single-beat
  // vector is requantised with the configuration presented alongside it.
  assign w_base      = r_first ? bus.cfg_bias  : r_acc;
  assign w_eff_shift = r_first ? bus.cfg_shift : r_shift;
  assign w_eff_relu  = r_first ? bus.cfg_relu  : r_relu;

  always_comb begin
    w_res   = sat_add(64'(w_base), 64'(bus.in_prod), ACC_W);
    w_sum   = ACC_W'(w_res.value);
    w_clamp = w_res.clamped;
  end

  requant_rsr #(
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) u_rsr (
    .acc_in (w_sum),
    .shift  (w_eff_shift),
    .relu   (w_eff_relu),
    .data   (w_req_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_first     <= 1'b1;
      r_ovf       <= 1'b0;
      r_shift     <= '0;
      r_relu      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_acc   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      // A consumed result drops valid unless a new last beat reloads it below.
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (r_first) begin
          r_shift <= bus.cfg_shift;
          r_relu  <= bus.cfg_relu;
        end
        if (bus.in_last) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_req_data;
          r_out_acc   <= w_sum;
          r_out_ovf   <= r_ovf | w_clamp;
          r_first     <= 1'b1;
          r_ovf       <= 1'b0;
          r_acc       <= '0;
        end else begin
          r_acc   <= w_sum;
          r_first <= 1'b0;
          r_ovf   <= r_ovf | w_clamp;
        end
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_acc   = r_out_acc;
  assign bus.out_ovf   = r_out_ovf;

endmodule : mac_accum_requant
`default_nettype wire
